// File: rtl/execute_y_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier for the Y execute lane.
// Operands are reduced to sign + magnitude on entry, multiplied unsigned,
// and the sign is re-applied in the output stage together with result-half
// selection and overflow detection. Extra stages beyond the minimum only
// add delay on the product path.
module execute_y_mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int REGW   = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_signed,
  input  logic             i_in_high,
  input  logic [WIDTH-1:0] i_in_rega,
  input  logic [WIDTH-1:0] i_in_regb,
  input  logic [REGW-1:0]  i_in_regdest,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [REGW-1:0]  o_out_regdest,
  output logic             o_out_writereg,
  output logic [WIDTH-1:0] o_out_wbvalue,
  output logic             o_out_overflow
);
  localparam int PW = 2 * WIDTH;

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign w_adv      = !r_vld_pipe[STAGES] || i_out_ready;
  assign o_in_ready = w_adv;

  // Entry: sign detect and magnitudes. A zero operand never yields a
  // negative sign, so -0 cannot appear downstream.
  logic             w_a_neg, w_b_neg, w_zero, w_neg;
  logic [WIDTH-1:0] w_maga, w_magb;

  assign w_a_neg = i_in_signed & i_in_rega[WIDTH-1];
  assign w_b_neg = i_in_signed & i_in_regb[WIDTH-1];
  assign w_maga  = w_a_neg ? -i_in_rega : i_in_rega;
  assign w_magb  = w_b_neg ? -i_in_regb : i_in_regb;
  assign w_zero  = (i_in_rega == '0) || (i_in_regb == '0);
  assign w_neg   = (w_a_neg ^ w_b_neg) & !w_zero;

  // Valid shift register: reset > flush > advance/hold.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) r_vld_pipe <= '0;
    else if (w_adv)         r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_in_valid};
  end

  // Control payload travelling alongside the product (stages 1..STAGES-1).
  logic             r_neg  [1:STAGES-1];
  logic             r_high [1:STAGES-1];
  logic             r_sgn  [1:STAGES-1];
  logic [REGW-1:0]  r_rd   [1:STAGES-1];
  logic [WIDTH-1:0] r_maga, r_magb;

  // Payload shift for the non-output stages; stage 1 captures the new op.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_maga <= '0;
      r_magb <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_neg[k]  <= 1'b0;
        r_high[k] <= 1'b0;
        r_sgn[k]  <= 1'b0;
        r_rd[k]   <= '0;
      end
    end else if (w_adv) begin
      r_maga  <= w_maga;
      r_magb  <= w_magb;
      r_neg[1]  <= w_neg;
      r_high[1] <= i_in_high;
      r_sgn[1]  <= i_in_signed;
      r_rd[1]   <= i_in_regdest;
      for (int k = 2; k < STAGES; k++) begin
        r_neg[k]  <= r_neg[k-1];
        r_high[k] <= r_high[k-1];
        r_sgn[k]  <= r_sgn[k-1];
        r_rd[k]   <= r_rd[k-1];
      end
    end
  end

  // Unsigned magnitude product feeding the output stage.
  logic [PW-1:0] w_prod_fin;

  generate
    if (STAGES == 2) begin : g_short
      assign w_prod_fin = PW'(r_maga) * PW'(r_magb);
    end else begin : g_long
      logic [PW-1:0] r_prod [2:STAGES-1];

      // Multiply in stage 2, then carry the product through delay stages.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          for (int k = 2; k < STAGES; k++) r_prod[k] <= '0;
        end else if (w_adv) begin
          r_prod[2] <= PW'(r_maga) * PW'(r_magb);
          for (int k = 3; k < STAGES; k++) r_prod[k] <= r_prod[k-1];
        end
      end

      assign w_prod_fin = r_prod[STAGES-1];
    end
  endgenerate

  // Output stage: re-apply sign, pick the half, detect low-half overflow.
  logic [PW-1:0]    w_p;
  logic [WIDTH-1:0] w_hi, w_res;
  logic             w_sovf, w_ovf;

  assign w_p    = r_neg[STAGES-1] ? -w_prod_fin : w_prod_fin;
  assign w_hi   = w_p[PW-1:WIDTH];
  // Signed fit: the upper W+1 bits must all equal the low-half sign bit.
  assign w_sovf = !((&w_p[PW-1:WIDTH-1]) || !(|w_p[PW-1:WIDTH-1]));
  assign w_ovf  = !r_high[STAGES-1] && (r_sgn[STAGES-1] ? w_sovf : |w_hi);
  assign w_res  = r_high[STAGES-1] ? w_hi : w_p[WIDTH-1:0];

  logic [REGW-1:0]  r_out_rd;
  logic [WIDTH-1:0] r_out_wb;
  logic             r_out_ovf;

  // Output payload register; held while the consumer stalls.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_rd  <= '0;
      r_out_wb  <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_adv) begin
      r_out_rd  <= r_rd[STAGES-1];
      r_out_wb  <= w_res;
      r_out_ovf <= w_ovf;
    end
  end

  // Payload is forced to zero whenever no result is presented.
  assign o_out_valid    = r_vld_pipe[STAGES];
  assign o_out_regdest  = o_out_valid ? r_out_rd : '0;
  assign o_out_wbvalue  = o_out_valid ? r_out_wb : '0;
  assign o_out_overflow = o_out_valid & r_out_ovf;
  assign o_out_writereg = o_out_valid & !r_out_ovf;

endmodule

// File: tb/tb_execute_y_mul_pipe.sv
// Bench for execute_y_mul_pipe (WIDTH=32, STAGES=4): table vectors, stall,
// flush, reset and a randomised back-pressure phase, all scored via a queue.
module tb_execute_y_mul_pipe;
  localparam int W = 32;
  localparam int S = 4;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_signed, in_high, out_ready;
  logic [W-1:0] rega, regb;
  logic [R-1:0] rd;
  logic         in_ready, out_valid, out_writereg, out_overflow;
  logic [R-1:0] out_rd;
  logic [W-1:0] out_wb;

  always #5 clk = ~clk;

  execute_y_mul_pipe #(.WIDTH(W), .STAGES(S), .REGW(R)) dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_signed(in_signed), .i_in_high(in_high),
    .i_in_rega(rega), .i_in_regb(regb), .i_in_regdest(rd),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_regdest(out_rd), .o_out_writereg(out_writereg),
    .o_out_wbvalue(out_wb), .o_out_overflow(out_overflow)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         s, h;
    logic [W-1:0] wb;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [R-1:0] rd;
    logic [W-1:0] wb;
    logic         ovf;
    int           acc;
    bit           strict;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0, n_pass = 0, cyc = 0;
  bit           strict = 1'b1;
  logic [W-1:0] cur_wb;
  logic         cur_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  // Independent reference: exact wide signed product of extended operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic h,
                                output logic [W-1:0] wb, output logic ovf);
    logic signed [65:0] pa, pb, p;
    pa = s ? {{34{a[W-1]}}, a} : {34'b0, a};
    pb = s ? {{34{b[W-1]}}, b} : {34'b0, b};
    p  = pa * pb;
    wb = h ? p[63:32] : p[31:0];
    if (h)      ovf = 1'b0;
    else if (s) ovf = (p < -66'sd2147483648) || (p > 66'sd2147483647);
    else        ovf = (p[63:32] != 32'd0);
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: push on accept, pop and compare on output handshake.
  exp_t e;
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("out_has_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("wbvalue",  64'(out_wb), 64'(e.wb));
          check("overflow", 64'(out_overflow), 64'(e.ovf));
          check("writereg", 64'(out_writereg), 64'(!e.ovf));
          check("regdest",  64'(out_rd), 64'(e.rd));
          if (e.strict) check("latency", 64'(cyc - e.acc), 64'(S));
        end
      end
      if (!out_valid)
        check("idle_zero", 64'({out_rd, out_wb, out_writereg, out_overflow}), 64'(0));
      if (in_valid && in_ready)
        q.push_back('{rd, cur_wb, cur_ovf, cyc, strict});
    end
  end

  // Present one op and hold it until accepted (bounded).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic h, input logic [R-1:0] d,
                       input logic [W-1:0] wb, input logic ovf);
    bit ok = 1'b0;
    rega = a; regb = b; in_signed = s; in_high = h; rd = d;
    cur_wb = wb; cur_ovf = ovf; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("issue_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  vec_t         tbl[16];
  logic [W-1:0] spec_v[5];
  logic [W-1:0] mw;
  logic         mo;

  initial begin
    tbl[0]  = '{32'h00000007, 32'hFFFFFFFA, 1, 0, 32'hFFFFFFD6, 0};
    tbl[1]  = '{32'h00010000, 32'h00010000, 0, 0, 32'h00000000, 1};
    tbl[2]  = '{32'h00010000, 32'h00010000, 0, 1, 32'h00000001, 0};
    tbl[3]  = '{32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, 1};
    tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h00000000, 0};
    tbl[5]  = '{32'h00000000, 32'hFFFFFFFF, 1, 0, 32'h00000000, 0};
    tbl[6]  = '{32'h00000000, 32'h80000000, 1, 1, 32'h00000000, 0};
    tbl[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFE, 0};
    tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000001, 1};
    tbl[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h00000000, 0};
    tbl[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'h00000001, 0};
    tbl[11] = '{32'h80000000, 32'h80000000, 1, 1, 32'h40000000, 0};
    tbl[12] = '{32'h7FFFFFFF, 32'h00000002, 1, 0, 32'hFFFFFFFE, 1};
    tbl[13] = '{32'hFFFF0000, 32'h00008000, 1, 0, 32'h80000000, 0};
    tbl[14] = '{32'h00000003, 32'hFFFFFFFE, 1, 1, 32'hFFFFFFFF, 0};
    tbl[15] = '{32'h0000FFFF, 32'h00010001, 0, 0, 32'hFFFFFFFF, 0};
    spec_v[0] = 32'h00000000; spec_v[1] = 32'h00000001; spec_v[2] = 32'hFFFFFFFF;
    spec_v[3] = 32'h80000000; spec_v[4] = 32'h7FFFFFFF;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_high = 1'b0;
    out_ready = 1'b1; rega = '0; regb = '0; rd = '0; cur_wb = '0; cur_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready), 64'(1));
    check("rst_outputs",   64'({out_rd, out_wb, out_writereg, out_overflow}), 64'(0));
    @(posedge clk); #1;

    // Table vectors, back-to-back, exact latency
    for (int i = 0; i < 16; i++)
      issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].h, R'(i + 1), tbl[i].wb, tbl[i].ovf);
    drain();

    // Stall: A..D back-to-back, consumer stalls 3 cycles once A shows up
    strict = 1'b0;
    issue(32'h00000007, 32'hFFFFFFFA, 1, 0, 5'd3,  32'hFFFFFFD6, 0);
    issue(32'h00000005, 32'h00000006, 0, 0, 5'd4,  32'h0000001E, 0);
    issue(32'h00010000, 32'h00010000, 0, 1, 5'd5,  32'h00000001, 0);
    issue(32'h80000000, 32'hFFFFFFFF, 1, 0, 5'd6,  32'h80000000, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready",  64'(in_ready), 64'(0));
      check("stall_hold_wb",   64'(out_wb), 64'(32'hFFFFFFD6));
      check("stall_hold_rd",   64'(out_rd), 64'(3));
      @(posedge clk); #1;
    end
    drain();
    strict = 1'b1;

    // Flush with two in flight and an op offered in the flush cycle
    issue(32'h00000009, 32'h00000009, 0, 0, 5'd10, 32'h00000051, 0);
    issue(32'h00000002, 32'h00000003, 0, 0, 5'd11, 32'h00000006, 0);
    rega = 32'd4; regb = 32'd4; rd = 5'd12; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_no_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
    end
    issue(32'hFFFFFFFD, 32'h00000004, 1, 0, 5'd13, 32'hFFFFFFF4, 0);
    drain();

    // Reset mid-operation with three in flight
    issue(32'h00000011, 32'h00000002, 0, 0, 5'd20, 32'h00000022, 0);
    issue(32'h00000012, 32'h00000002, 0, 0, 5'd21, 32'h00000024, 0);
    issue(32'h00000013, 32'h00000002, 0, 0, 5'd22, 32'h00000026, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid",   64'(out_valid), 64'(0));
    check("midrst_outputs", 64'({out_rd, out_wb, out_writereg, out_overflow}), 64'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    issue(32'hFFFFFFFF, 32'h00000002, 1, 0, 5'd23, 32'hFFFFFFFE, 0);
    drain();

    // Random ops under random back-pressure; only accepted ops are scored
    strict = 1'b0;
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      rega      = ($urandom_range(0, 2) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      regb      = ($urandom_range(0, 2) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      in_signed = $urandom_range(0, 1);
      in_high   = $urandom_range(0, 1);
      rd        = R'($urandom);
      model(rega, regb, in_signed, in_high, mw, mo);
      cur_wb = mw; cur_ovf = mo;
      @(posedge clk); #1;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
